// File: rtl/cpu_pkg.sv
`default_nettype none
// ==== cpu_pkg : shared constants and types for the fetch front end (rev 1.0) ====
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam int unsigned PF_DEPTH_DEFAULT = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } pf_entry_t;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_BUSY  = 2'd1,
    FS_DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`default_nettype none
// ==== prefetch_fifo : synchronous DEPTH-entry FIFO with flush and occupancy count (rev 1.0) ====
module prefetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = PF_DEPTH_DEFAULT,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             w_push;
  logic             w_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_pop  = pop_i && !empty_o;
  assign w_push = push_i && (!full_o || w_pop);

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/if_prefetch.sv
`default_nettype none
// ==== if_prefetch : instruction prefetch buffer with one outstanding fetch and redirect discard (rev 1.0) ====
module if_prefetch
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH    = PF_DEPTH_DEFAULT,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc_plus4,
  output logic        instr_valid
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;

  logic          w_ack;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_next;
  pf_entry_t     w_wdata;
  pf_entry_t     w_head;

  assign w_ack   = imem_ack && (state_q != FS_IDLE);
  assign w_pop   = !w_empty && !stall && !redirect;
  // Data from a request issued before a redirect (DRAIN) is dropped on arrival.
  assign w_push  = w_ack && (state_q == FS_BUSY) && !redirect && (!w_full || w_pop);
  assign w_wdata = '{instr: imem_rdata, pc_plus4: next_pc(addr_q)};

  always_comb begin
    w_count_next = w_count;
    if (redirect)              w_count_next = '0;
    else if (w_push && !w_pop) w_count_next = w_count + 1'b1;
    else if (!w_push && w_pop) w_count_next = w_count - 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;

    if (redirect)    fetch_pc_d = redirect_pc;
    else if (w_push) fetch_pc_d = next_pc(fetch_pc_q);

    case (state_q)
      FS_BUSY: begin
        if (w_ack)         state_d = FS_IDLE;
        else if (redirect) state_d = FS_DRAIN;
      end
      FS_DRAIN: begin
        if (w_ack) state_d = FS_IDLE;
      end
      default: state_d = FS_IDLE;
    endcase

    // Issue only with room for the returning word once the current cycle settles.
    if (state_d == FS_IDLE && w_count_next < CW'(DEPTH)) begin
      state_d = FS_BUSY;
      addr_d  = fetch_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FS_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .data_i  (w_wdata),
    .pop_i   (w_pop),
    .flush_i (redirect),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  assign imem_req       = (state_q != FS_IDLE);
  assign imem_addr      = addr_q;
  assign instr_valid    = !w_empty;
  assign instr          = w_empty ? NOP_INSTR : w_head.instr;
  assign instr_pc_plus4 = w_empty ? 32'h0000_0000 : w_head.pc_plus4;

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch.sv
`default_nettype none
// ==== tb_if_prefetch : directed scenarios plus randomized run against a queue model (rev 1.0) ====
module tb_if_prefetch;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc4;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc_plus4;
  logic        instr_valid;

  logic        mem_auto;
  logic        ack_man;
  logic [31:0] salt;
  int          mem_lat;
  int          wait_cnt;

  logic        wp_rst;
  logic        wp_redirect;
  logic [31:0] wp_redirect_pc;
  logic        wp_stall;
  logic        wp_req;
  logic [31:0] wp_addr;
  logic [31:0] wp_instr;
  logic [31:0] wp_pc4;
  logic        wp_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_ack   = mem_auto ? (imem_req && (wait_cnt >= mem_lat)) : ack_man;
  assign imem_rdata = imem_addr ^ salt;

  always @(posedge clk) wait_cnt <= (!imem_req || imem_ack) ? 0 : wait_cnt + 1;

  if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .instr_pc_plus4 (instr_pc_plus4),
    .instr_valid    (instr_valid)
  );

  if_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk            (clk),
    .rst            (wp_rst),
    .redirect       (wp_redirect),
    .redirect_pc    (wp_redirect_pc),
    .stall          (wp_stall),
    .imem_req       (wp_req),
    .imem_addr      (wp_addr),
    .imem_ack       (wp_req),
    .imem_rdata     (wp_addr),
    .instr          (wp_instr),
    .instr_pc_plus4 (wp_pc4),
    .instr_valid    (wp_valid)
  );

  // Leaves the bench in the first cycle after the edge that samples rst low.
  task automatic do_reset(input int lat, input logic auto_ack, input logic [31:0] s);
    rst = 1'b1; redirect = 1'b0; stall = 1'b0; ack_man = 1'b0;
    mem_auto = auto_ack; mem_lat = lat; salt = s; redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_auto = 1'b0; ack_man = 1'b1; redirect = 1'b1;
    redirect_pc = 32'h40; stall = 1'b0; salt = 32'h0; mem_lat = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc_plus4 !== 32'h0) begin
      errors++; $display("FAIL reset_out valid=%0b instr=%h pc4=%h exp 0/0/0", instr_valid, instr, instr_pc_plus4);
    end
    redirect = 1'b0; ack_man = 1'b0;
  endtask

  task automatic test_stream;
    do_reset(0, 1'b1, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (k - 1))) begin
        errors++; $display("FAIL stream_addr cyc=%0d req=%0b addr=%h exp=%h", k, imem_req, imem_addr, 32'(4 * (k - 1)));
      end
      checks++;
      if (k >= 2) begin
        if (instr_valid !== 1'b1 || instr !== 32'(4 * (k - 2)) || instr_pc_plus4 !== 32'(4 * (k - 1))) begin
          errors++; $display("FAIL stream_instr cyc=%0d valid=%0b instr=%h pc4=%h exp %h/%h", k, instr_valid, instr, instr_pc_plus4, 32'(4 * (k - 2)), 32'(4 * (k - 1)));
        end
      end else if (instr_valid !== 1'b0 || instr !== 32'h0) begin
        errors++; $display("FAIL stream_first valid=%0b instr=%h exp 0/0", instr_valid, instr);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall;
    logic [31:0] exp_i;
    int got;
    do_reset(0, 1'b1, 32'h0);
    stall = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      if (k >= 5) begin
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_full cyc=%0d req=%0b exp=0", k, imem_req); end
      end
      if (k == 10) begin
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h0) begin
          errors++; $display("FAIL stall_head valid=%0b instr=%h exp 1/0", instr_valid, instr);
        end
      end
      @(negedge clk);
    end
    stall = 1'b0;
    exp_i = 32'h0; got = 0;
    for (int k = 0; k < 12; k++) begin
      if (instr_valid === 1'b1) begin
        checks++;
        if (instr !== exp_i || instr_pc_plus4 !== exp_i + 32'd4) begin
          errors++; $display("FAIL stall_drain instr=%h pc4=%h exp %h/%h", instr, instr_pc_plus4, exp_i, exp_i + 32'd4);
        end
        exp_i = exp_i + 32'd4; got++;
      end
      @(negedge clk);
    end
    checks++;
    if (got != 12) begin errors++; $display("FAIL stall_release_count got=%0d exp=12", got); end
  endtask

  task automatic test_redirect_latency;
    int n;
    do_reset(1, 1'b1, 32'h0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL redir_pre req=%0b addr=%h exp 1/0", imem_req, imem_addr);
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL redir_hold req=%0b addr=%h valid=%0b exp 1/0/0", imem_req, imem_addr, instr_valid);
    end
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL redir_newaddr req=%0b addr=%h valid=%0b exp 1/100/0", imem_req, imem_addr, instr_valid);
    end
    n = 0;
    while (instr_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h0000_0100 || instr_pc_plus4 !== 32'h0000_0104) begin
      errors++; $display("FAIL redir_first valid=%0b instr=%h pc4=%h exp 1/100/104", instr_valid, instr, instr_pc_plus4);
    end
  endtask

  task automatic test_redirect_pop_ack;
    logic [31:0] exp_i;
    do_reset(0, 1'b1, 32'h0);
    @(negedge clk); @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      errors++; $display("FAIL rpa_pre valid=%0b req=%0b addr=%h exp 1/1/8", instr_valid, imem_req, imem_addr);
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc_plus4 !== 32'h0 || imem_addr !== 32'h200) begin
      errors++; $display("FAIL rpa_empty valid=%0b instr=%h pc4=%h addr=%h exp 0/0/0/200", instr_valid, instr, instr_pc_plus4, imem_addr);
    end
    exp_i = 32'h0000_0200;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (instr_valid === 1'b1) begin
        checks++;
        if (instr !== exp_i || instr_pc_plus4 !== exp_i + 32'd4) begin
          errors++; $display("FAIL rpa_seq instr=%h pc4=%h exp %h/%h", instr, instr_pc_plus4, exp_i, exp_i + 32'd4);
        end
        exp_i = exp_i + 32'd4;
      end
    end
    checks++;
    if (exp_i == 32'h0000_0200) begin errors++; $display("FAIL rpa_progress got=none exp=words from 200"); end
  endtask

  task automatic test_wrap;
    logic [31:0] ea;
    wp_rst = 1'b1;
    repeat (2) @(negedge clk);
    wp_rst = 1'b0;
    @(negedge clk);
    ea = 32'hFFFF_FFF8;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (wp_req !== 1'b1 || wp_addr !== ea) begin
        errors++; $display("FAIL wrap_addr cyc=%0d req=%0b addr=%h exp=%h", k, wp_req, wp_addr, ea);
      end
      if (k >= 2) begin
        checks++;
        if (wp_valid !== 1'b1 || wp_instr !== ea - 32'd4 || wp_pc4 !== ea) begin
          errors++; $display("FAIL wrap_instr cyc=%0d valid=%0b instr=%h pc4=%h exp %h/%h", k, wp_valid, wp_instr, wp_pc4, ea - 32'd4, ea);
        end
      end
      ea = ea + 32'd4;
      @(negedge clk);
    end
    wp_rst = 1'b1;
  endtask

  task automatic test_rst_mid_request;
    do_reset(0, 1'b0, 32'hDEAD_0000);
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC || instr_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_pending req=%0b addr=%h valid=%0b exp 1/0/0", imem_req, imem_addr, instr_valid);
    end
    rst = 1'b1; ack_man = 1'b1;
    @(negedge clk);
    rst = 1'b0; ack_man = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0) begin
      errors++; $display("FAIL rstmid_cleared req=%0b valid=%0b instr=%h exp 0/0/0", imem_req, instr_valid, instr);
    end
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC || instr_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_restart req=%0b addr=%h valid=%0b exp 1/0/0", imem_req, imem_addr, instr_valid);
    end
    ack_man = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'hDEAD_0000 || instr_pc_plus4 !== 32'h4) begin
      errors++; $display("FAIL rstmid_word valid=%0b instr=%h pc4=%h exp 1/dead0000/4", instr_valid, instr, instr_pc_plus4);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rstmid_single valid=%0b exp=0", instr_valid); end
  endtask

  task automatic test_random;
    ent_t        mq[$];
    ent_t        e;
    logic [31:0] m_pc, m_paddr, e_instr, e_pc4;
    bit          m_pend, m_disc, ackd, do_pop;
    m_pc = RESET_PC; m_paddr = RESET_PC; m_pend = 1'b0; m_disc = 1'b0;
    mem_auto = 1'b0; salt = 32'h1234_0000;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst         = (cyc < 2) || ($urandom_range(0, 63) == 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      stall       = ($urandom_range(0, 3) == 0);
      ack_man     = ($urandom_range(0, 1) == 1);
      #1;
      if (rst) begin
        mq.delete(); m_pc = RESET_PC; m_pend = 1'b0; m_disc = 1'b0;
      end else begin
        ackd   = m_pend && ack_man;
        do_pop = (mq.size() != 0) && !stall && !redirect;
        if (do_pop) void'(mq.pop_front());
        if (ackd) begin
          if (!m_disc && !redirect) begin
            e.ins = m_paddr ^ salt; e.pc4 = m_paddr + 32'd4;
            mq.push_back(e);
            m_pc = m_paddr + 32'd4;
          end
          m_pend = 1'b0; m_disc = 1'b0;
        end
        if (redirect) begin
          mq.delete(); m_pc = redirect_pc;
          if (m_pend) m_disc = 1'b1;
        end
        if (!m_pend && mq.size() < int'(DEPTH)) begin m_pend = 1'b1; m_paddr = m_pc; end
      end
      @(negedge clk);
      e_instr = (mq.size() != 0) ? mq[0].ins : 32'h0;
      e_pc4   = (mq.size() != 0) ? mq[0].pc4 : 32'h0;
      checks++;
      if (imem_req !== m_pend || (m_pend && imem_addr !== m_paddr) || instr_valid !== (mq.size() != 0) ||
          instr !== e_instr || instr_pc_plus4 !== e_pc4) begin
        errors++;
        $display("FAIL random cyc=%0d req=%0b addr=%h valid=%0b instr=%h pc4=%h exp req=%0b addr=%h valid=%0b instr=%h pc4=%h",
                 cyc, imem_req, imem_addr, instr_valid, instr, instr_pc_plus4,
                 m_pend, m_paddr, (mq.size() != 0), e_instr, e_pc4);
      end
    end
  endtask

  initial begin
    wp_rst = 1'b1; wp_redirect = 1'b0; wp_redirect_pc = 32'h0; wp_stall = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_latency();
    test_redirect_pop_ack();
    test_wrap();
    test_rst_mid_request();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
